// File: rtl/snitch_icache_perf_cnt.sv
// snitch_icache_perf_cnt
// Sink for the per-fetch-port L0 instruction-cache events. Each event bit
// feeds its own saturating counter with a sticky saturation flag. Counters
// are read through a single-entry valid/ready request/response port.
module snitch_icache_perf_cnt #(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned PORT_IW        = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic [5*NR_FETCH_PORTS-1:0] events_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [PORT_IW-1:0]          req_port_i,
    input  logic [2:0]                  req_event_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [CNT_WIDTH-1:0]        rsp_data_o,
    output logic                        rsp_sat_o,
    output logic                        rsp_err_o
);

    // Counter i is event bit i of events_i, i.e. index = port*5 + event.
    localparam int unsigned NR_CNT = 5 * NR_FETCH_PORTS;
    localparam logic [PORT_IW:0] NR_PORTS_W = (PORT_IW + 1)'(NR_FETCH_PORTS);

    logic [CNT_WIDTH-1:0] r_cnt [NR_CNT];
    logic [NR_CNT-1:0]    r_sat;

    logic                 r_rsp_valid;
    logic [CNT_WIDTH-1:0] r_rsp_data;
    logic                 r_rsp_sat;
    logic                 r_rsp_err;

    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_addr_err;
    logic [CNT_WIDTH-1:0] w_sel_data;
    logic                 w_sel_sat;

    // Counter update: clear beats increment, increment saturates at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_CNT; i++) begin
                r_cnt[i] <= '0;
            end
            r_sat <= '0;
        end else begin
            for (int unsigned i = 0; i < NR_CNT; i++) begin
                if (clear_i) begin
                    r_cnt[i] <= '0;
                    r_sat[i] <= 1'b0;
                end else if (enable_i && events_i[i]) begin
                    if (r_cnt[i] == '1) begin
                        r_sat[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Single-entry response slot: accept when empty or being drained.
    always_comb begin
        w_req_ready = !r_rsp_valid || rsp_ready_i;
        w_accept    = req_valid_i && w_req_ready;
        w_addr_err  = ({1'b0, req_port_i} >= NR_PORTS_W) || (req_event_i > 3'd4);
    end

    // Read mux over the registered counter values (pre-update this cycle).
    always_comb begin
        w_sel_data = '0;
        w_sel_sat  = 1'b0;
        for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
            for (int unsigned e = 0; e < 5; e++) begin
                if (req_port_i == PORT_IW'(p) && req_event_i == 3'(e)) begin
                    w_sel_data = r_cnt[p*5 + e];
                    w_sel_sat  = r_sat[p*5 + e];
                end
            end
        end
    end

    // Response register: load on accept, otherwise drain on rsp_ready_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_sat   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_addr_err ? '0 : w_sel_data;
            r_rsp_sat   <= w_addr_err ? 1'b0 : w_sel_sat;
            r_rsp_err   <= w_addr_err;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign req_ready_o = w_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_sat_o   = r_rsp_sat;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Directed bench for snitch_icache_perf_cnt (3 fetch ports, 4-bit counters).
module tb_snitch_icache_perf_cnt;

    localparam int unsigned NP = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          clear;
    logic [5*NP-1:0] events;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_port;
    logic [2:0]    req_event;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [CW-1:0] rsp_data;
    logic          rsp_sat;
    logic          rsp_err;

    int unsigned n_chk;
    int unsigned n_err;

    snitch_icache_perf_cnt #(
        .NR_FETCH_PORTS (NP),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .clear_i     (clear),
        .events_i    (events),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_port_i  (req_port),
        .req_event_i (req_event),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_sat_o   (rsp_sat),
        .rsp_err_o   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] port;
        logic [2:0]    ev;
        int unsigned   data;
        bit            sat;
        bit            err;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One event pattern held for one clock edge.
    task automatic pulse(input logic [5*NP-1:0] v, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            events = v;
            tick();
        end
        events = '0;
    endtask

    // Issue a read, check the response one cycle after acceptance, let it drain.
    task automatic rd(input string name, input logic [IW-1:0] p, input logic [2:0] e,
                      input int unsigned xd, input bit xs, input bit xe);
        int unsigned w;
        req_valid = 1'b1;
        req_port  = p;
        req_event = e;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: request not accepted within 20 cycles", name);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        chk({name, ".valid"}, 32'(rsp_valid), 1);
        chk({name, ".data"},  32'(rsp_data), xd);
        chk({name, ".sat"},   32'(rsp_sat), 32'(xs));
        chk({name, ".err"},   32'(rsp_err), 32'(xe));
        tick();
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        events    = '0;
        req_valid = 1'b0;
        req_port  = '0;
        req_event = '0;
        rsp_ready = 1'b1;

        tbl[0]  = '{port: 2'd1, ev: 3'd3, data: 8, sat: 1'b0, err: 1'b0};
        tbl[1]  = '{port: 2'd0, ev: 3'd4, data: 4, sat: 1'b0, err: 1'b0};
        tbl[2]  = '{port: 2'd0, ev: 3'd3, data: 1, sat: 1'b0, err: 1'b0};
        tbl[3]  = '{port: 2'd0, ev: 3'd2, data: 1, sat: 1'b0, err: 1'b0};
        tbl[4]  = '{port: 2'd0, ev: 3'd1, data: 1, sat: 1'b0, err: 1'b0};
        tbl[5]  = '{port: 2'd0, ev: 3'd0, data: 1, sat: 1'b0, err: 1'b0};
        tbl[6]  = '{port: 2'd1, ev: 3'd4, data: 1, sat: 1'b0, err: 1'b0};
        tbl[7]  = '{port: 2'd2, ev: 3'd0, data: 1, sat: 1'b0, err: 1'b0};
        tbl[8]  = '{port: 2'd3, ev: 3'd0, data: 0, sat: 1'b0, err: 1'b1};
        tbl[9]  = '{port: 2'd0, ev: 3'd5, data: 0, sat: 1'b0, err: 1'b1};
        tbl[10] = '{port: 2'd2, ev: 3'd7, data: 0, sat: 1'b0, err: 1'b1};

        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst.req_ready", 32'(req_ready), 1);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.rsp_data",  32'(rsp_data), 0);
        chk("rst.rsp_sat",   32'(rsp_sat), 0);
        chk("rst.rsp_err",   32'(rsp_err), 0);
        rd("rst.read04", 2'd0, 3'd4, 0, 1'b0, 1'b0);

        // Counting: port1 hit x7, port0 miss x3, then every bit once
        enable = 1'b1;
        pulse(15'(1) << (1*5 + 3), 7);
        pulse(15'(1) << (0*5 + 4), 3);
        pulse('1, 1);
        for (int i = 0; i < 11; i++) begin
            rd($sformatf("tbl%0d", i), tbl[i].port, tbl[i].ev, tbl[i].data, tbl[i].sat, tbl[i].err);
        end

        // Saturation at 4 bits
        clear = 1'b1; tick(); clear = 1'b0;
        pulse(15'(1), 20);
        rd("sat.read00", 2'd0, 3'd0, 15, 1'b1, 1'b0);
        rd("sat.read01", 2'd0, 3'd1, 0, 1'b0, 1'b0);
        clear = 1'b1; tick(); clear = 1'b0;
        rd("sat.clr00", 2'd0, 3'd0, 0, 1'b0, 1'b0);

        // Clear wins over a same-cycle event; disabled counting holds
        pulse(15'(1), 2);
        clear  = 1'b1;
        events = 15'(1);
        tick();
        clear  = 1'b0;
        events = '0;
        rd("clrev.read00", 2'd0, 3'd0, 0, 1'b0, 1'b0);
        pulse(15'(1), 2);
        enable = 1'b0;
        pulse(15'(1), 10);
        rd("dis.read00", 2'd0, 3'd0, 2, 1'b0, 1'b0);
        enable = 1'b1;

        // Read accepted in the same cycle as an increment returns the old value
        pulse(15'(1) << 3, 5);
        req_valid = 1'b1;
        req_port  = 2'd0;
        req_event = 3'd3;
        events    = 15'(1) << 3;
        tick();
        req_valid = 1'b0;
        events    = '0;
        chk("race.data", 32'(rsp_data), 5);
        tick();
        rd("race.next", 2'd0, 3'd3, 6, 1'b0, 1'b0);

        // Backpressure: response held, new request stalled while events keep counting
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_port  = 2'd0;
        req_event = 3'd3;
        tick();
        events = 15'(1) << 3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d.valid", k), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d.ready", k), 32'(req_ready), 0);
            chk($sformatf("bp%0d.data", k),  32'(rsp_data), 6);
            tick();
        end
        events    = '0;
        rsp_ready = 1'b1;
        #1;
        chk("bp.ready_release", 32'(req_ready), 1);
        tick();
        req_port  = 2'd0;
        req_event = 3'd0;
        chk("bp.pending_data", 32'(rsp_data), 10);
        chk("b2b0.valid", 32'(rsp_valid), 1);
        tick();
        req_valid = 1'b0;
        chk("b2b1.valid", 32'(rsp_valid), 1);
        chk("b2b1.data",  32'(rsp_data), 2);
        tick();
        chk("drain.valid", 32'(rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/snitch_icache_perf_cnt.md
Name: snitch_icache_perf_cnt

Overview:
- Consumer end of the instruction-cache event interface. Takes the per-fetch-port L0 event vectors (miss, hit, prefetch, double_hit, stall) and accumulates them in saturating counters.
- Exposes the counters through a valid/ready read-request / read-response port. This port is bridged to the cluster peripheral register file.
- Sits beside the icache top. It is the single sink of all `icache_events_t` outputs.

Parameters:
- NR_FETCH_PORTS, 2, number of fetch ports; one event vector each.
- CNT_WIDTH, 32, width of each counter in bits (>=2).
- PORT_IW, `$clog2(NR_FETCH_PORTS)` with a minimum of 1, width of the port-select field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- enable_i  in  1  counting enable; when 0, counters hold.
- clear_i  in  1  synchronous clear of all counters and sticky bits.
- events_i  in  5*NR_FETCH_PORTS  port p at [p*5 +: 5], in packed struct order:
  - bit 4 = l0_miss
  - bit 3 = l0_hit
  - bit 2 = l0_prefetch
  - bit 1 = l0_double_hit
  - bit 0 = l0_stall
- req_valid_i  in  1  read request valid.
- req_ready_o  out  1  read request accepted.
- req_port_i  in  PORT_IW  fetch port index.
- req_event_i  in  3  event index; equals the bit position in the port's vector (0 = stall ... 4 = miss).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  CNT_WIDTH  counter value.
- rsp_sat_o  out  1  sticky saturation flag of the addressed counter.
- rsp_err_o  out  1  address out of range.

Behaviour:
- Storage:
  - 5*NR_FETCH_PORTS counters of CNT_WIDTH bits.
  - One sticky sat bit per counter.
- Reset (rst_ni low, asynchronous):
  - All counters = 0 and all sat bits = 0.
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_sat_o = 0, rsp_err_o = 0.
  - req_ready_o = 1 once reset is released. Reset mid-transaction drops any pending response.
- Counting (per cycle, per counter):
  - Priority is clear_i > increment > hold.
  - clear_i = 1: counter <= 0 and sat <= 0. An event in the same cycle is discarded.
  - Else if enable_i = 1 and the event bit = 1:
    - If the counter is below all-ones, counter <= counter + 1.
    - Else the counter stays at all-ones and sat <= 1 (saturating; it never wraps).
  - Else: hold.
  - Multiple bits in one port's vector, or the same event on several ports, increment their own counters independently in the same cycle.
- Read handshake:
  - The response path is a single-entry register. req_ready_o = !rsp_valid_o || rsp_ready_i (combinational).
  - A request is accepted when req_valid_i && req_ready_o.
  - The response is valid in the next cycle (latency 1).
  - Captured data is the counter's registered value at the start of the acceptance cycle. It excludes any increment or clear happening in that cycle.
  - rsp_sat_o is captured the same way.
  - When no new request is accepted, rsp_valid_o clears on rsp_ready_i.
  - Back-to-back requests with rsp_ready_i held at 1 give one response per cycle.
  - While rsp_valid_o && !rsp_ready_i: rsp_data_o, rsp_sat_o and rsp_err_o are held stable, and req_ready_o = 0.
- Address check:
  - req_port_i >= NR_FETCH_PORTS or req_event_i > 4 gives: rsp_err_o = 1, rsp_data_o = 0, rsp_sat_o = 0.
  - The response is still delivered with normal timing.
- Reads never modify counters; there is no clear-on-read.
- Widths:
  - Counter increment is CNT_WIDTH wide.
  - Saturation is detected as counter == {CNT_WIDTH{1'b1}} before the increment.

Test Plan:
- Reset, then idle for 5 cycles -> req_ready_o = 1, rsp_valid_o = 0. A read of port 0 / event 4 then returns data 0, sat 0, err 0 one cycle after acceptance.
- enable_i = 1; port 1 l0_hit pulsed for 7 cycles and port 0 l0_miss for 3 cycles, all bits in one cycle as well -> read (1,3) = 8 and (0,4) = 4. Port 0 hit, prefetch, double_hit and stall read 1 each.
- CNT_WIDTH = 4; 20 l0_stall pulses on port 0 -> read (0,0): data = 15, sat = 1. After clear_i pulse: data = 0, sat = 0.
- clear_i and an event in the same cycle -> counter = 0 afterwards. enable_i = 0 with 10 events -> counter unchanged.
- Request accepted in the same cycle as an increment of counter (0,3) that was at 5 -> response data = 5. Next read = 6.
- rsp_ready_i held at 0 for 4 cycles after a response -> req_ready_o = 0 and the data is stable; a pending req_valid_i is not accepted. Requesting port NR_FETCH_PORTS or event 5 -> err = 1, data = 0.
